// File: rtl/stream_demux32_1to2_if.sv
// Handshake bundle for the 1-to-2 stream demux: one input stream, two output streams
// and the per-port delivered-word counters.
interface stream_demux32_1to2_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
);
  logic [WIDTH-1:0] in_data;
  logic             in_sel;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out0_data;
  logic             out0_valid;
  logic             out0_ready;
  logic [WIDTH-1:0] out1_data;
  logic             out1_valid;
  logic             out1_ready;
  logic [CNT_W-1:0] cnt0;
  logic [CNT_W-1:0] cnt1;

  modport slave (
    input  in_data, in_sel, in_valid, out0_ready, out1_ready,
    output in_ready, out0_data, out0_valid, out1_data, out1_valid, cnt0, cnt1
  );

  modport master (
    output in_data, in_sel, in_valid, out0_ready, out1_ready,
    input  in_ready, out0_data, out0_valid, out1_data, out1_valid, cnt0, cnt1
  );
endinterface

// File: rtl/stream_demux32_1to2.sv
// Routes each input word to one of two single-entry holding registers (1-cycle latency).
// in_ready follows only the selected port, so a stalled port never blocks the other one.
module stream_demux32_1to2 #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  stream_demux32_1to2_if.slave  bus
);
  logic [WIDTH-1:0] r_dat0;
  logic [WIDTH-1:0] r_dat1;
  logic             r_vld0;
  logic             r_vld1;
  logic [CNT_W-1:0] r_cnt0;
  logic [CNT_W-1:0] r_cnt1;

  logic w_rdy0;
  logic w_rdy1;
  logic w_in_rdy;
  logic w_ld0;
  logic w_ld1;
  logic w_pop0;
  logic w_pop1;

  // A port can take a word when empty or when its current word leaves this cycle.
  assign w_rdy0   = !r_vld0 || bus.out0_ready;
  assign w_rdy1   = !r_vld1 || bus.out1_ready;
  assign w_in_rdy = bus.in_sel ? w_rdy1 : w_rdy0;

  assign w_ld0  = bus.in_valid && w_in_rdy && !bus.in_sel;
  assign w_ld1  = bus.in_valid && w_in_rdy &&  bus.in_sel;
  assign w_pop0 = r_vld0 && bus.out0_ready;
  assign w_pop1 = r_vld1 && bus.out1_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_dat0 <= '0;
      r_dat1 <= '0;
      r_vld0 <= 1'b0;
      r_vld1 <= 1'b0;
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else begin
      if (w_ld0) begin
        r_dat0 <= bus.in_data;
        r_vld0 <= 1'b1;
      end else if (w_pop0) begin
        r_vld0 <= 1'b0;
      end
      if (w_ld1) begin
        r_dat1 <= bus.in_data;
        r_vld1 <= 1'b1;
      end else if (w_pop1) begin
        r_vld1 <= 1'b0;
      end
      if (w_pop0) r_cnt0 <= r_cnt0 + 1'b1;
      if (w_pop1) r_cnt1 <= r_cnt1 + 1'b1;
    end
  end

  assign bus.in_ready   = w_in_rdy;
  assign bus.out0_data  = r_dat0;
  assign bus.out0_valid = r_vld0;
  assign bus.out1_data  = r_dat1;
  assign bus.out1_valid = r_vld1;
  assign bus.cnt0       = r_cnt0;
  assign bus.cnt1       = r_cnt1;
endmodule

// File: tb/tb_stream_demux32_1to2.sv
// Directed and randomized checks of the 1-to-2 stream demux against hand-computed values
// and a per-port queue model.
module tb_stream_demux32_1to2;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  stream_demux32_1to2_if #(.WIDTH(32), .CNT_W(8)) bus ();

  stream_demux32_1to2 #(.WIDTH(32), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [31:0] q0[$];
    logic [31:0] q1[$];
    logic [31:0] exp_w;
    int          pops0;
    int          pops1;
    logic        exp_rdy;

    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.in_data = '0;
    bus.in_sel = 1'b0;
    bus.in_valid = 1'b0;
    bus.out0_ready = 1'b0;
    bus.out1_ready = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
    #1;
    chk("rst_out0_valid", 32'(bus.out0_valid), 32'd0);
    chk("rst_out1_valid", 32'(bus.out1_valid), 32'd0);
    chk("rst_out0_data", bus.out0_data, 32'd0);
    chk("rst_out1_data", bus.out1_data, 32'd0);
    chk("rst_cnt0", 32'(bus.cnt0), 32'd0);
    chk("rst_cnt1", 32'(bus.cnt1), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Basic routing to port 0
    bus.in_data = 32'h00000043; bus.in_sel = 1'b0; bus.in_valid = 1'b1;
    cyc();
    bus.in_valid = 1'b0;
    #1;
    chk("route0_valid", 32'(bus.out0_valid), 32'd1);
    chk("route0_data", bus.out0_data, 32'h00000043);
    chk("route0_out1_valid", 32'(bus.out1_valid), 32'd0);
    chk("route0_cnt0", 32'(bus.cnt0), 32'd0);

    // Second word to port 1, then drain port 0
    bus.in_data = 32'h8000007F; bus.in_sel = 1'b1; bus.in_valid = 1'b1;
    cyc();
    bus.in_valid = 1'b0;
    #1;
    chk("route1_data", bus.out1_data, 32'h8000007F);
    chk("route1_valid", 32'(bus.out1_valid), 32'd1);
    chk("route1_hold0", bus.out0_data, 32'h00000043);
    chk("route1_hold0_valid", 32'(bus.out0_valid), 32'd1);
    bus.out0_ready = 1'b1;
    cyc();
    bus.out0_ready = 1'b0;
    #1;
    chk("drain0_valid", 32'(bus.out0_valid), 32'd0);
    chk("drain0_cnt0", 32'(bus.cnt0), 32'd1);
    chk("drain0_keep_data", bus.out0_data, 32'h00000043);
    chk("drain0_out1_kept", 32'(bus.out1_valid), 32'd1);
    bus.out1_ready = 1'b1;
    cyc();
    bus.out1_ready = 1'b0;
    #1;
    chk("drain1_valid", 32'(bus.out1_valid), 32'd0);
    chk("drain1_cnt1", 32'(bus.cnt1), 32'd1);

    // Backpressure on port 0 must not block port 1
    bus.in_data = 32'h000000AA; bus.in_sel = 1'b0; bus.in_valid = 1'b1;
    cyc();
    bus.in_data = 32'h000000BB;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
      cyc();
      chk("bp_hold_data", bus.out0_data, 32'h000000AA);
      chk("bp_hold_valid", 32'(bus.out0_valid), 32'd1);
    end
    bus.in_data = 32'h000000CC; bus.in_sel = 1'b1;
    #1;
    chk("bp_other_ready", 32'(bus.in_ready), 32'd1);
    cyc();
    bus.in_valid = 1'b0;
    #1;
    chk("bp_other_data", bus.out1_data, 32'h000000CC);
    chk("bp_other_valid", 32'(bus.out1_valid), 32'd1);
    chk("bp_port0_untouched", bus.out0_data, 32'h000000AA);
    bus.out0_ready = 1'b1; bus.out1_ready = 1'b1;
    cyc();
    bus.out0_ready = 1'b0; bus.out1_ready = 1'b0;
    #1;
    chk("bp_cnt0", 32'(bus.cnt0), 32'd2);
    chk("bp_cnt1", 32'(bus.cnt1), 32'd2);

    // Full throughput on port 0
    bus.out0_ready = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      bus.in_data = 32'(i); bus.in_sel = 1'b0; bus.in_valid = 1'b1;
      #1;
      chk("thru_in_ready", 32'(bus.in_ready), 32'd1);
      cyc();
      chk("thru_data", bus.out0_data, 32'(i));
      chk("thru_valid", 32'(bus.out0_valid), 32'd1);
    end
    bus.in_valid = 1'b0;
    cyc();
    bus.out0_ready = 1'b0;
    #1;
    chk("thru_empty", 32'(bus.out0_valid), 32'd0);
    chk("thru_cnt0", 32'(bus.cnt0), 32'd12);

    // Counter wrap on port 1 starting from a fresh reset
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    #1;
    chk("wrap_pre_cnt1", 32'(bus.cnt1), 32'd0);
    bus.out1_ready = 1'b1;
    for (int j = 0; j < 256; j++) begin
      bus.in_data = 32'(j); bus.in_sel = 1'b1; bus.in_valid = 1'b1;
      cyc();
    end
    bus.in_valid = 1'b0;
    #1;
    chk("wrap_cnt1_ff", 32'(bus.cnt1), 32'h000000FF);
    chk("wrap_last_data", bus.out1_data, 32'd255);
    cyc();
    bus.out1_ready = 1'b0;
    #1;
    chk("wrap_cnt1_zero", 32'(bus.cnt1), 32'd0);
    chk("wrap_cnt0_untouched", 32'(bus.cnt0), 32'd0);

    // Reset discards held words and overrides same-cycle handshakes
    bus.in_data = 32'h00000011; bus.in_sel = 1'b0; bus.in_valid = 1'b1;
    cyc();
    bus.in_data = 32'h00000022; bus.in_sel = 1'b1;
    cyc();
    bus.in_valid = 1'b0;
    #1;
    chk("load_both0", 32'(bus.out0_valid), 32'd1);
    chk("load_both1", 32'(bus.out1_valid), 32'd1);
    rst_n = 1'b0;
    bus.out0_ready = 1'b1; bus.out1_ready = 1'b1;
    bus.in_data = 32'h00000033; bus.in_sel = 1'b0; bus.in_valid = 1'b1;
    cyc();
    bus.in_valid = 1'b0;
    #1;
    chk("rst2_out0_valid", 32'(bus.out0_valid), 32'd0);
    chk("rst2_out1_valid", 32'(bus.out1_valid), 32'd0);
    chk("rst2_out0_data", bus.out0_data, 32'd0);
    chk("rst2_out1_data", bus.out1_data, 32'd0);
    chk("rst2_cnt0", 32'(bus.cnt0), 32'd0);
    chk("rst2_cnt1", 32'(bus.cnt1), 32'd0);
    rst_n = 1'b1;
    cyc();
    cyc();
    chk("post_rst_out0_valid", 32'(bus.out0_valid), 32'd0);
    chk("post_rst_out1_valid", 32'(bus.out1_valid), 32'd0);
    chk("post_rst_cnt0", 32'(bus.cnt0), 32'd0);
    chk("post_rst_cnt1", 32'(bus.cnt1), 32'd0);

    // Randomized traffic against per-port queues
    pops0 = 0;
    pops1 = 0;
    for (int c = 0; c < 10000; c++) begin
      bus.in_valid   = ($urandom_range(0, 3) != 0);
      bus.in_sel     = 1'($urandom_range(0, 1));
      bus.in_data    = $urandom;
      bus.out0_ready = ($urandom_range(0, 2) != 0);
      bus.out1_ready = ($urandom_range(0, 3) == 0);
      #1;
      chk("rnd_valid0", 32'(bus.out0_valid), 32'(q0.size() != 0));
      chk("rnd_valid1", 32'(bus.out1_valid), 32'(q1.size() != 0));
      exp_rdy = bus.in_sel ? ((q1.size() == 0) || bus.out1_ready)
                           : ((q0.size() == 0) || bus.out0_ready);
      chk("rnd_in_ready", 32'(bus.in_ready), 32'(exp_rdy));
      if (q0.size() != 0 && bus.out0_ready) begin
        exp_w = q0.pop_front();
        chk("rnd_data0", bus.out0_data, exp_w);
        pops0++;
      end
      if (q1.size() != 0 && bus.out1_ready) begin
        exp_w = q1.pop_front();
        chk("rnd_data1", bus.out1_data, exp_w);
        pops1++;
      end
      if (bus.in_valid && exp_rdy) begin
        if (bus.in_sel) q1.push_back(bus.in_data);
        else            q0.push_back(bus.in_data);
      end
      cyc();
    end
    bus.in_valid = 1'b0;
    #1;
    chk("rnd_cnt0", 32'(bus.cnt0), 32'(pops0 % 256));
    chk("rnd_cnt1", 32'(bus.cnt1), 32'(pops1 % 256));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
